// File: rtl/button_debouncer_pkg.sv
// ----------------------------------------------------------------------------
// button_debouncer_pkg
// Shared definitions for the push-button conditioner: default parameter
// values, the per-channel filter state encoding and the counter-width helper.
// No ports (package).
// ----------------------------------------------------------------------------
package button_debouncer_pkg;

  localparam int unsigned DEFAULT_NUM_BUTTONS     = 32'd2;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd500000;

  // Filter state of one channel. It is derived from comparing the synchronized
  // pin with the accepted level, so it is never stored in a register.
  typedef enum logic {
    CH_STABLE  = 1'b0,  // synchronized pin equals the accepted level
    CH_CONFIRM = 1'b1   // pin differs, counting toward a level flip
  } chan_state_e;

  // Bits needed to hold 0..cycles in the stability counter.
  function automatic int unsigned count_width(input int unsigned cycles);
    return $clog2(cycles + 32'd1);
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// ----------------------------------------------------------------------------
// button_debouncer_if
// Groups the button signals of the debouncer.
//   button_raw   : raw asynchronous pin levels (driven by the board side)
//   button_level : debounced level
//   button_rise  : one-cycle pulse on a 0->1 level change
//   button_fall  : one-cycle pulse on a 1->0 level change
// Modports: master = pin/consumer side, slave = debouncer side.
// ----------------------------------------------------------------------------
interface button_debouncer_if
  import button_debouncer_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS = DEFAULT_NUM_BUTTONS
);

  logic [NUM_BUTTONS-1:0] button_raw;
  logic [NUM_BUTTONS-1:0] button_level;
  logic [NUM_BUTTONS-1:0] button_rise;
  logic [NUM_BUTTONS-1:0] button_fall;

  modport master (
    output button_raw,
    input  button_level,
    input  button_rise,
    input  button_fall
  );

  modport slave (
    input  button_raw,
    output button_level,
    output button_rise,
    output button_fall
  );

endinterface

// File: rtl/debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
// One push-button channel: 2-FF synchronizer followed by a counter-based
// stability filter with registered rise/fall pulses.
//   clock : system clock
//   reset : synchronous, active-high reset
//   raw   : raw asynchronous pin level
//   level : debounced level (flop output)
//   rise  : one-cycle pulse when level goes 0->1 (flop output)
//   fall  : one-cycle pulse when level goes 1->0 (flop output)
// ----------------------------------------------------------------------------
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned         CNT_W    = count_width(DEBOUNCE_CYCLES);
  // Count value at which the next disagreeing edge accepts the new level.
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;
  chan_state_e      state_s;

  // Filter state is implied by pin/level agreement.
  assign state_s = (sync2_q == level_q) ? CH_STABLE : CH_CONFIRM;

  // Next-state logic of the stability filter.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_s)
      CH_STABLE: begin
        // Any return to the accepted level discards a partial count.
        cnt_d = '0;
      end
      CH_CONFIRM: begin
        if (cnt_q == CNT_LAST) begin
          level_d = sync2_q;
          cnt_d   = '0;
          rise_d  = sync2_q;
          fall_d  = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Synchronizer, filter and pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      level_q <= RESET_LEVEL;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
// Multi-channel push-button conditioner. Each bit of the interface is handled
// by an independent debounce_channel; all outputs come straight from flops.
//   clock : system clock (SoC domain)
//   reset : synchronous, active-high reset
//   bus   : button_debouncer_if slave (button_raw in; level/rise/fall out)
// ----------------------------------------------------------------------------
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned            NUM_BUTTONS     = DEFAULT_NUM_BUTTONS,
  parameter int unsigned            DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [NUM_BUTTONS-1:0] RESET_LEVEL     = '0
) (
  input  logic                clock,
  input  logic                reset,
  button_debouncer_if.slave   bus
);

  logic [NUM_BUTTONS-1:0] level_s;
  logic [NUM_BUTTONS-1:0] rise_s;
  logic [NUM_BUTTONS-1:0] fall_s;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL[i])
    ) u_channel (
      .clock (clock),
      .reset (reset),
      .raw   (bus.button_raw[i]),
      .level (level_s[i]),
      .rise  (rise_s[i]),
      .fall  (fall_s[i])
    );
  end

  assign bus.button_level = level_s;
  assign bus.button_rise  = rise_s;
  assign bus.button_fall  = fall_s;

endmodule

// File: tb/tb_button_debouncer.sv
// ----------------------------------------------------------------------------
// tb_button_debouncer
// Directed stimulus with hand-computed expected output events, checked by a
// scoreboard monitor. DEBOUNCE_CYCLES=4, so a change settles 6 edges later.
// ----------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int LAT = 6;  // DEBOUNCE_CYCLES + 2 edges from pin change

  typedef struct {
    int         cyc;
    logic [1:0] level;
    logic [1:0] rise;
    logic [1:0] fall;
  } exp_t;

  logic clock;
  logic reset;
  int   cyc;
  int   compared;
  int   mismatched;
  exp_t exp_q[$];
  exp_t e;
  logic [1:0] prev_level;

  button_debouncer_if #(.NUM_BUTTONS(2)) bus_if ();

  button_debouncer #(
    .NUM_BUTTONS     (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_LEVEL     (2'b00)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_at(input int c, input logic [1:0] lv,
                           input logic [1:0] r, input logic [1:0] f);
    exp_t x;
    x.cyc = c; x.level = lv; x.rise = r; x.fall = f;
    exp_q.push_back(x);
  endtask

  // Scoreboard monitor: checks reset outputs, and pops an expected event
  // whenever the DUT shows a pulse or a level change.
  initial begin
    prev_level = 2'b00;
    forever begin
      @(negedge clock);
      if (reset) begin
        compared++;
        if ({bus_if.button_level, bus_if.button_rise, bus_if.button_fall} !== 6'b0) begin
          mismatched++;
          $display("FAIL reset_outputs cyc=%0d got level=%b rise=%b fall=%b want all 0",
                   cyc, bus_if.button_level, bus_if.button_rise, bus_if.button_fall);
        end
        prev_level = bus_if.button_level;
      end else if (bus_if.button_rise !== 2'b00 || bus_if.button_fall !== 2'b00 ||
                   bus_if.button_level !== prev_level) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_event cyc=%0d got level=%b rise=%b fall=%b want no event",
                   cyc, bus_if.button_level, bus_if.button_rise, bus_if.button_fall);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.level !== bus_if.button_level ||
              e.rise !== bus_if.button_rise || e.fall !== bus_if.button_fall) begin
            mismatched++;
            $display("FAIL event cyc=%0d got level=%b rise=%b fall=%b want cyc=%0d level=%b rise=%b fall=%b",
                     cyc, bus_if.button_level, bus_if.button_rise, bus_if.button_fall,
                     e.cyc, e.level, e.rise, e.fall);
          end
        end
        prev_level = bus_if.button_level;
      end
    end
  end

  // Directed stimulus.
  initial begin
    compared   = 0;
    mismatched = 0;
    reset = 1'b1;
    bus_if.button_raw = 2'b11;

    // Reset with pins high: transition accepted 6 edges after release.
    wait_cyc(3);
    reset = 1'b0;
    expect_at(cyc + LAT, 2'b11, 2'b11, 2'b00);
    wait_cyc(10);

    // Both released together.
    bus_if.button_raw = 2'b00;
    expect_at(cyc + LAT, 2'b00, 2'b00, 2'b11);
    wait_cyc(10);

    // Clean press on channel 0.
    bus_if.button_raw = 2'b01;
    expect_at(cyc + LAT, 2'b01, 2'b01, 2'b00);
    wait_cyc(10);
    bus_if.button_raw = 2'b00;
    expect_at(cyc + LAT, 2'b00, 2'b00, 2'b01);
    wait_cyc(10);

    // Bounce 1,0,1,0 at 2-cycle intervals then hold 1.
    for (int k = 0; k < 4; k++) begin
      bus_if.button_raw = (k % 2 == 0) ? 2'b01 : 2'b00;
      wait_cyc(2);
    end
    bus_if.button_raw = 2'b01;
    expect_at(cyc + LAT, 2'b01, 2'b01, 2'b00);
    wait_cyc(10);

    // 3-cycle drop is rejected.
    bus_if.button_raw = 2'b00;
    wait_cyc(3);
    bus_if.button_raw = 2'b01;
    wait_cyc(10);

    // 4-cycle drop is accepted, then the return is accepted too.
    bus_if.button_raw = 2'b00;
    expect_at(cyc + LAT, 2'b00, 2'b00, 2'b01);
    wait_cyc(4);
    bus_if.button_raw = 2'b01;
    expect_at(cyc + LAT, 2'b01, 2'b01, 2'b00);
    wait_cyc(10);
    bus_if.button_raw = 2'b00;
    expect_at(cyc + LAT, 2'b00, 2'b00, 2'b01);
    wait_cyc(10);

    // Reset mid-count discards the partial count.
    bus_if.button_raw = 2'b01;
    wait_cyc(4);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    expect_at(cyc + LAT, 2'b01, 2'b01, 2'b00);
    wait_cyc(10);
    bus_if.button_raw = 2'b00;
    expect_at(cyc + LAT, 2'b00, 2'b00, 2'b01);
    wait_cyc(10);

    // Simultaneous channels.
    bus_if.button_raw = 2'b11;
    expect_at(cyc + LAT, 2'b11, 2'b11, 2'b00);
    wait_cyc(10);
    bus_if.button_raw = 2'b00;
    expect_at(cyc + LAT, 2'b00, 2'b00, 2'b11);
    wait_cyc(10);

    // Every expected event must have been seen.
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL missing_events got %0d pending want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
